// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: FSM state encoding and a counter-width helper.
package arith_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Smallest r with 2**r >= v; used to size counters that must hold the value v-1.
  function automatic int unsigned clog2_fn(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell: sum and carry of three input bits.
module full_adder (
  input  logic a_in,
  input  logic b_in,
  input  logic c_in,
  output logic sum_out,
  output logic car_out
);

  assign sum_out = a_in ^ b_in ^ c_in;
  assign car_out = (a_in & b_in) | (c_in & (a_in ^ b_in));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full_adder cell fed LSB first, with valid/ready on both sides.
module serial_adder_ctrl
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = clog2_fn(WIDTH + 1)
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             in_valid_in,
  output logic             in_ready_out,
  input  logic [WIDTH-1:0] a_data_in,
  input  logic [WIDTH-1:0] b_data_in,
  input  logic             c_in,
  output logic             out_valid_out,
  input  logic             out_ready_in,
  output logic [WIDTH-1:0] sum_data_out,
  output logic             car_out,
  output logic             busy_out
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh, b_sh, sum_sh, sum_next;
  logic             carry_q;
  logic [CNT_W-1:0] count_q;
  logic             fa_sum, fa_car;
  logic             last_bit;

  full_adder u_full_adder (
    .a_in    (a_sh[0]),
    .b_in    (b_sh[0]),
    .c_in    (carry_q),
    .sum_out (fa_sum),
    .car_out (fa_car)
  );

  assign last_bit = (count_q == CNT_W'(WIDTH - 1));

  // New sum bit enters at the MSB so the LSB-first stream lands in place after WIDTH shifts.
  if (WIDTH == 1) begin : g_sum_w1
    assign sum_next = fa_sum;
  end else begin : g_sum_wn
    assign sum_next = {fa_sum, sum_sh[WIDTH-1:1]};
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid_in)  state_d = ST_RUN;
      ST_RUN:  if (last_bit)     state_d = ST_DONE;
      ST_DONE: if (out_ready_in) state_d = ST_IDLE;
      default:                   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= ST_IDLE;
      a_sh    <= '0;
      b_sh    <= '0;
      sum_sh  <= '0;
      carry_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && in_valid_in) begin
        a_sh    <= a_data_in;
        b_sh    <= b_data_in;
        carry_q <= c_in;
        count_q <= '0;
      end else if (state_q == ST_RUN) begin
        a_sh    <= a_sh >> 1;
        b_sh    <= b_sh >> 1;
        sum_sh  <= sum_next;
        carry_q <= fa_car;
        count_q <= count_q + CNT_W'(1);
      end
    end
  end

  assign in_ready_out  = (state_q == ST_IDLE);
  assign out_valid_out = (state_q == ST_DONE);
  assign busy_out      = (state_q == ST_RUN);
  assign sum_data_out  = sum_sh;
  assign car_out       = carry_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: an 8-bit and a 1-bit instance on a shared clock.
module tb_serial_adder_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready, busy, c, car;
  logic [7:0] a, b, sum;
  logic       u_in_valid, u_in_ready, u_out_valid, u_out_ready, u_busy, u_c, u_car;
  logic [0:0] u_a, u_b, u_sum;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk_in        (clk),
    .rst_in        (rst),
    .in_valid_in   (in_valid),
    .in_ready_out  (in_ready),
    .a_data_in     (a),
    .b_data_in     (b),
    .c_in          (c),
    .out_valid_out (out_valid),
    .out_ready_in  (out_ready),
    .sum_data_out  (sum),
    .car_out       (car),
    .busy_out      (busy)
  );

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk_in        (clk),
    .rst_in        (rst),
    .in_valid_in   (u_in_valid),
    .in_ready_out  (u_in_ready),
    .a_data_in     (u_a),
    .b_data_in     (u_b),
    .c_in          (u_c),
    .out_valid_out (u_out_valid),
    .out_ready_in  (u_out_ready),
    .sum_data_out  (u_sum),
    .car_out       (u_car),
    .busy_out      (u_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns at the first sample with out_valid high; n = edges after the accepting edge.
  task automatic run8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                      output int n, output int acc);
    int w;
    a = ta; b = tb; c = tc; in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 50) begin tick(); w++; end
    check("accept8_timeout", (w < 50), 1);
    tick();
    acc = cyc;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin tick(); n++; end
    check("valid8_timeout", (n < 50), 1);
  endtask

  task automatic run1(input logic ta, input logic tb, input logic tc, output int n);
    int w;
    u_a = ta; u_b = tb; u_c = tc; u_in_valid = 1'b1;
    w = 0;
    while (!u_in_ready && w < 20) begin tick(); w++; end
    check("accept1_timeout", (w < 20), 1);
    tick();
    u_in_valid = 1'b0;
    n = 0;
    while (!u_out_valid && n < 20) begin tick(); n++; end
    check("valid1_timeout", (n < 20), 1);
  endtask

  initial begin
    int n, acc0, acc1, acc2;
    logic seen;
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; c = 1'b0;
    u_in_valid = 1'b0; u_out_ready = 1'b1; u_a = '0; u_b = '0; u_c = 1'b0;
    tick(); tick();

    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_sum", sum, 0);
    check("rst_car", car, 0);
    check("rst_w1_in_ready", u_in_ready, 1);
    check("rst_w1_out_valid", u_out_valid, 0);
    rst = 1'b0;
    tick();

    // 0x0F + 0x01, held in DONE under backpressure.
    run8(8'h0F, 8'h01, 1'b0, n, acc0);
    check("lat_0f01_cycles", n + 1, 9);  // accept cycle counted as cycle 0
    check("sum_0f01", sum, 8'h10);
    check("car_0f01", car, 0);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin a = 8'hAA; b = 8'h55; c = 1'b1; in_valid = 1'b1; end
      tick();
      in_valid = 1'b0;
      check("bp_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_sum", sum, 8'h10);
      check("bp_car", car, 0);
    end
    out_ready = 1'b1;
    tick();
    check("bp_release_valid", out_valid, 0);
    check("bp_release_idle", in_ready, 1);
    check("bp_release_busy", busy, 0);
    check("bp_hold_sum", sum, 8'h10);

    run8(8'hFF, 8'h01, 1'b0, n, acc0);
    check("sum_ff01", sum, 8'h00);
    check("car_ff01", car, 1);
    run8(8'hFF, 8'hFF, 1'b1, n, acc0);
    check("sum_ffff1", sum, 8'hFF);
    check("car_ffff1", car, 1);
    tick();

    // Reset three edges into RUN aborts the job.
    a = 8'h5A; b = 8'h33; c = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    check("abort_busy_before", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_sum", sum, 0);
    check("abort_car", car, 0);
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin tick(); seen = seen | out_valid; end
    check("abort_no_valid", seen, 0);

    // Back-to-back with out_ready tied high.
    out_ready = 1'b1;
    run8(8'h12, 8'h34, 1'b0, n, acc0);
    check("b2b0_sum", sum, 8'h46);
    check("b2b0_car", car, 0);
    run8(8'h80, 8'h80, 1'b0, n, acc1);
    check("b2b1_sum", sum, 8'h00);
    check("b2b1_car", car, 1);
    run8(8'h00, 8'h00, 1'b1, n, acc2);
    check("b2b2_sum", sum, 8'h01);
    check("b2b2_car", car, 0);
    check("b2b_interval1", acc1 - acc0, 10);
    check("b2b_interval2", acc2 - acc1, 10);
    tick();

    // WIDTH=1: exhaustive over a, b, c.
    begin
      logic [2:0] v;
      for (int i = 0; i < 8; i++) begin
        v = 3'(i);
        run1(v[2], v[1], v[0], n);
        check("w1_lat_cycles", n + 1, 2);
        check("w1_result", {u_car, u_sum}, 32'(v[2]) + 32'(v[1]) + 32'(v[0]));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
